rst_seq_gen: RTL and testbench

RST_SEQ_GEN -- requirements
Module: rst_seq_gen

---
 rtl/rst_seq_gen.sv | 116 +++++++++++
 tb/tb_rst_seq_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronizes rst_n, then releases G_NB_STAGES active-low
// domain resets in index order, G_STAGE_DELAY cycles apart; re-runnable by soft request.
module rst_seq_gen #(
   parameter int G_NB_STAGES   = 4,
   parameter int G_SYNC_STAGES = 2,
   parameter int G_STAGE_DELAY = 8,
   parameter int G_CNT_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   soft_rst_req,
   output logic                   rst_n_sync,
   output logic [G_NB_STAGES-1:0] rst_n_stage,
   output logic                   init_done,
   output logic                   busy,
   output logic [G_CNT_WIDTH-1:0] cycle_cnt,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      S_SYNC    = 2'd0,
      S_RELEASE = 2'd1,
      S_DONE    = 2'd2,
      S_SOFT    = 2'd3
   } state_t;

   localparam int IDX_W = (G_NB_STAGES > 1) ? $clog2(G_NB_STAGES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G_NB_STAGES - 1);
   localparam logic [7:0]       DLY_MAX  = 8'(G_STAGE_DELAY - 1);

   logic [G_SYNC_STAGES-1:0] sync_ff;
   state_t                   state, state_nxt;
   logic [7:0]               dly_cnt, dly_nxt;
   logic [IDX_W-1:0]         stage_idx, idx_nxt;
   logic [G_NB_STAGES-1:0]   stage_nxt;
   logic                     done_nxt;
   logic                     soft_block, block_nxt;

   // Asynchronous assertion, synchronous deassertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_ff <= '0;
      else        sync_ff <= {sync_ff[G_SYNC_STAGES-2:0], 1'b1};
   end
   assign rst_n_sync = sync_ff[G_SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_SYNC;
         dly_cnt     <= '0;
         stage_idx   <= '0;
         rst_n_stage <= '0;
         init_done   <= 1'b0;
         soft_block  <= 1'b0;
      end else begin
         state       <= state_nxt;
         dly_cnt     <= dly_nxt;
         stage_idx   <= idx_nxt;
         rst_n_stage <= stage_nxt;
         init_done   <= done_nxt;
         soft_block  <= block_nxt;
      end
   end

   // soft_block stops a held request from re-triggering until it is seen low.
   always_comb begin
      state_nxt = state;
      dly_nxt   = dly_cnt;
      idx_nxt   = stage_idx;
      stage_nxt = rst_n_stage;
      done_nxt  = init_done;
      block_nxt = soft_block & soft_rst_req;
      case (state)
         S_SYNC: begin
            // Leave on the edge where rst_n_sync itself rises (T0).
            if (sync_ff[G_SYNC_STAGES-2]) begin
               state_nxt = S_RELEASE;
               dly_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         S_RELEASE, S_SOFT: begin
            if (dly_cnt == DLY_MAX) begin
               dly_nxt   = '0;
               stage_nxt = rst_n_stage | (G_NB_STAGES'(1) << stage_idx);
               if (stage_idx == LAST_IDX) state_nxt = S_DONE;
               else                       idx_nxt   = stage_idx + IDX_W'(1);
            end else begin
               dly_nxt = dly_cnt + 8'd1;
            end
         end
         S_DONE: begin
            done_nxt = 1'b1;
            if (soft_rst_req && !soft_block) begin
               state_nxt = S_SOFT;
               stage_nxt = '0;
               done_nxt  = 1'b0;
               dly_nxt   = '0;
               idx_nxt   = '0;
               block_nxt = 1'b1;
            end
         end
         default: state_nxt = S_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cycle_cnt <= '0;
      else if (rst_n_sync && (cycle_cnt != {G_CNT_WIDTH{1'b1}}))
         cycle_cnt <= cycle_cnt + G_CNT_WIDTH'(1);
   end

   assign busy      = (state == S_RELEASE) || (state == S_SOFT);
   assign dbg_state = state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default, single-stage/unit-delay and 8-bit
// counter instances share clk/rst_n; expectations come from release-time formulas.
module tb_rst_seq_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic m_soft = 1'b0;
   logic s_soft = 1'b0;
   logic c_soft = 1'b0;

   logic        m_sync, m_done, m_busy;
   logic [3:0]  m_stage;
   logic [31:0] m_cnt;
   logic [1:0]  m_dbg;

   logic        s_sync, s_done, s_busy;
   logic [0:0]  s_stage;
   logic [31:0] s_cnt;
   logic [1:0]  s_dbg;

   logic        c_sync, c_done, c_busy;
   logic [3:0]  c_stage;
   logic [7:0]  c_cnt;
   logic [1:0]  c_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int t0_off   = 0;
   int seq_off  = 0;

   always #5 clk = ~clk;

   rst_seq_gen u_dut (
      .clk(clk), .rst_n(rst_n), .soft_rst_req(m_soft), .rst_n_sync(m_sync),
      .rst_n_stage(m_stage), .init_done(m_done), .busy(m_busy),
      .cycle_cnt(m_cnt), .dbg_state(m_dbg)
   );

   rst_seq_gen #(.G_NB_STAGES(1), .G_STAGE_DELAY(1)) u_small (
      .clk(clk), .rst_n(rst_n), .soft_rst_req(s_soft), .rst_n_sync(s_sync),
      .rst_n_stage(s_stage), .init_done(s_done), .busy(s_busy),
      .cycle_cnt(s_cnt), .dbg_state(s_dbg)
   );

   rst_seq_gen #(.G_CNT_WIDTH(8)) u_cnt8 (
      .clk(clk), .rst_n(rst_n), .soft_rst_req(c_soft), .rst_n_sync(c_sync),
      .rst_n_stage(c_stage), .init_done(c_done), .busy(c_busy),
      .cycle_cnt(c_cnt), .dbg_state(c_dbg)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t0_off=%0d seq_off=%0d)",
                    tag, obs, exp, t0_off, seq_off);
   endtask

   function automatic logic [3:0] exp_stages(input int t, input int d);
      logic [3:0] v = '0;
      for (int k = 0; k < 4; k++) if (t >= (k + 1) * d) v[k] = 1'b1;
      return v;
   endfunction

   // Lower stages must always be released before higher ones.
   always @(negedge clk) begin
      if (rst_n) begin
         check("m_order", 64'((m_stage & (m_stage + 4'd1)) == 4'd0), 64'd1);
         check("c_order", 64'((c_stage & (c_stage + 4'd1)) == 4'd0), 64'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      t0_off++;
      seq_off++;
   endtask

   task automatic check_all();
      check("m_sync",  64'(m_sync), 64'd1);
      check("m_stage", 64'(m_stage), 64'(exp_stages(seq_off, 8)));
      check("m_done",  64'(m_done), 64'(seq_off >= 33));
      check("m_busy",  64'(m_busy), 64'(seq_off < 32));
      check("m_cnt",   64'(m_cnt), 64'(t0_off));
      check("s_stage", 64'(s_stage), 64'(t0_off >= 1));
      check("s_done",  64'(s_done), 64'(t0_off >= 2));
      check("s_busy",  64'(s_busy), 64'(t0_off < 1));
      check("c_stage", 64'(c_stage), 64'(exp_stages(t0_off, 8)));
      check("c_cnt",   64'(c_cnt), 64'((t0_off > 255) ? 255 : t0_off));
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sync"},  64'(m_sync), 64'd0);
      check({tag, "_stage"}, 64'(m_stage), 64'd0);
      check({tag, "_done"},  64'(m_done), 64'd0);
      check({tag, "_busy"},  64'(m_busy), 64'd0);
      check({tag, "_cnt"},   64'(m_cnt), 64'd0);
      check({tag, "_dbg"},   64'(m_dbg), 64'd0);
      check({tag, "_sstg"},  64'(s_stage), 64'd0);
      check({tag, "_ccnt"},  64'(c_cnt), 64'd0);
   endtask

   // rst_n has just gone high, before edge E; rst_n_sync rises at E+1 = T0.
   task automatic start_seq();
      @(posedge clk);
      #1;
      check("e_sync", 64'(m_sync), 64'd0);
      check("e_cnt",  64'(m_cnt), 64'd0);
      @(posedge clk);
      #1;
      t0_off  = 0;
      seq_off = 0;
      check("t0_dbg", 64'(m_dbg), 64'd1);
      check_all();
   endtask

   task automatic glitch(input string tag);
      rst_n = 1'b0;
      #1;
      check_reset(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      start_seq();

      // Initial release; a soft request during S_RELEASE is ignored.
      for (int t = 1; t <= 40; t++) begin
         if (t == 12) m_soft = 1'b1;
         tick();
         m_soft = 1'b0;
         check_all();
      end

      // Single-cycle soft request in S_DONE.
      m_soft = 1'b1;
      tick();
      seq_off = 0;
      m_soft = 1'b0;
      check("ts_dbg", 64'(m_dbg), 64'd3);
      check_all();
      for (int u = 1; u <= 35; u++) begin
         tick();
         check_all();
      end

      // Request held high: exactly one re-sequence.
      m_soft = 1'b1;
      tick();
      seq_off = 0;
      check_all();
      for (int u = 1; u <= 80; u++) begin
         tick();
         check_all();
      end
      m_soft = 1'b0;
      check("held_dbg", 64'(m_dbg), 64'd2);

      // Sub-cycle glitch in S_DONE, then again at T0+20 mid-release.
      glitch("g1");
      start_seq();
      for (int t = 1; t <= 20; t++) begin
         tick();
         check_all();
      end
      glitch("g2");
      start_seq();

      // Full restart, then long S_DONE dwell for 8-bit counter saturation.
      for (int t = 1; t <= 300; t++) begin
         tick();
         check_all();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
